// File: rtl/score_pkg.sv
// Shared score/display constants and sequencer state encoding.
// Optional leading-zero blanking is enabled with LEADING_ZERO_BLANK_EN.
package score_pkg;

  localparam int DEF_SCORE_W    = 14;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_SAT_VALUE  = 9999;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to each BCD nibble >= 5,
// then shift {bcd, bin} left by one bit.
module bcd_dabble_step #(
  parameter int BCD_W = 16,
  parameter int BIN_W = 14
) (
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic [BIN_W-1:0] bin_o
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (adj[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
    end
  end

  assign {bcd_o, bin_o} = {adj[BCD_W-2:0], bin_i, 1'b0};

endmodule

// File: rtl/score_digit_sequencer.sv
// Binary score to BCD digits, committed only on frame_sync.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_digit_sequencer
  import score_pkg::*;
#(
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SAT_VALUE  = DEF_SAT_VALUE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_valid,
  input  logic                    frame_sync,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    busy,
  output logic                    commit
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CW    = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(SAT_VALUE);
  localparam logic [CW-1:0] CNT_INIT = CW'(SCORE_W);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] EN_RST = NUM_DIGITS'(1);
`else
  localparam logic [NUM_DIGITS-1:0] EN_RST = '1;
`endif

  logic [1:0]            state_q, state_d;
  logic [SCORE_W-1:0]    cap_q, cap_d;
  logic                  pend_q, pend_d;
  logic [SCORE_W-1:0]    pscore_q, pscore_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [SCORE_W-1:0]    bin_q, bin_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]      digits_q, digits_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  commit_q, commit_d;

  logic [BCD_W-1:0]      step_bcd;
  logic [SCORE_W-1:0]    step_bin;
  logic [NUM_DIGITS-1:0] en_calc;
  logic                  wait_commit;

  bcd_dabble_step #(
    .BCD_W (BCD_W),
    .BIN_W (SCORE_W)
  ) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (step_bcd),
    .bin_o (step_bin)
  );

  always_comb begin
    en_calc = '1;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
        seen = seen | (bcd_q[4*k +: 4] != 4'd0);
        en_calc[k] = seen;
      end
    end
`endif
  end

  assign wait_commit = (state_q == ST_WAIT) && frame_sync;

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    pend_d   = pend_q;
    pscore_d = pscore_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    en_d     = en_q;
    commit_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (score_valid) begin
          cap_d   = score;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bin_d   = (cap_q > SAT) ? SAT : cap_q;
        bcd_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d = step_bcd;
        bin_d = step_bin;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_sync) begin
          digits_d = bcd_q;
          en_d     = en_calc;
          commit_d = 1'b1;
          // a request arriving with the commit is newest and wins
          if (score_valid || pend_q) begin
            cap_d   = score_valid ? score : pscore_q;
            pend_d  = 1'b0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (score_valid && state_q != ST_IDLE && !wait_commit) begin
      pend_d   = 1'b1;
      pscore_d = score;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cap_q    <= '0;
      pend_q   <= 1'b0;
      pscore_q <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      en_q     <= EN_RST;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      pend_q   <= pend_d;
      pscore_q <= pscore_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      en_q     <= en_d;
      commit_q <= commit_d;
    end
  end

  assign digits   = digits_q;
  assign digit_en = en_q;
  assign commit   = commit_q;
  assign busy     = (state_q != ST_IDLE) | pend_q | commit_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench for score_digit_sequencer with a timestamp-based
// reference model; honours LEADING_ZERO_BLANK_EN like the design.
module tb_score_digit_sequencer;

  localparam int SW = 14;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic        busy;
  logic        commit;

  score_digit_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .frame_sync  (frame_sync),
    .digits      (digits),
    .digit_en    (digit_en),
    .busy        (busy),
    .commit      (commit)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int commit_cnt = 0;
  bit saw300 = 1'b0;
  bit started = 1'b0;

  // model state
  int cyc = 0;
  bit m_conv = 0;
  int m_val = 0;
  int m_ready = 0;
  bit m_pend = 0;
  int m_pval = 0;
  bit m_commit = 0;
  int m_disp = 0;

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int to_bcd(input int v);
    int r, p;
    r = 0;
    p = v;
    for (int k = 0; k < 4; k++) begin
      r = r + ((p % 10) << (4 * k));
      p = p / 10;
    end
    return r;
  endfunction

  function automatic int exp_en(input int v);
    int e, lim;
    if (BLANK == 0) return 15;
    e = 1;
    lim = 10;
    for (int k = 1; k < 4; k++) begin
      if (v >= lim) e = e | (1 << k);
      lim = lim * 10;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // reference model: a conversion may commit from m_ready onward
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_conv = 0; m_pend = 0; m_commit = 0; m_disp = 0; cyc = 0;
    end else begin
      m_commit = 0;
      if (!m_conv) begin
        if (score_valid) begin
          m_conv = 1;
          m_val = sat(int'(score));
          m_ready = cyc + SW + 2;
        end
      end else if (cyc >= m_ready && frame_sync) begin
        m_commit = 1;
        m_disp = m_val;
        if (score_valid || m_pend) begin
          m_val = sat(score_valid ? int'(score) : m_pval);
          m_ready = cyc + SW + 2;
          m_pend = 0;
        end else begin
          m_conv = 0;
        end
      end else if (score_valid) begin
        m_pend = 1;
        m_pval = int'(score);
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("digits", int'(digits), to_bcd(m_disp));
      chk("digit_en", int'(digit_en), exp_en(m_disp));
      chk("busy", int'(busy), int'(m_conv | m_pend | m_commit));
      chk("commit", int'(commit), int'(m_commit));
      if (commit) commit_cnt++;
      if (digits == 16'h0300) saw300 = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    score = 14'(v);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  int c0;

  initial begin
    tick();
    started = 1'b1;
    run(2);
    chk("rst_digits", int'(digits), 0);
    chk("rst_en", int'(digit_en), BLANK ? 1 : 15);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    run(2);

    // score 0, frame at cycle 20
    send(0);
    run(19);
    pulse_fs();
    chk("t1_commit", int'(commit), 1);
    chk("t1_digits", int'(digits), 'h0000);
    chk("t1_en", int'(digit_en), BLANK ? 'b0001 : 'b1111);
    run(1);
    chk("t1_busy_low", int'(busy), 0);

    // 1234 with a frame every 40 cycles
    c0 = commit_cnt;
    send(1234);
    for (int c = 1; c <= 120; c++) begin
      frame_sync = (c % 40 == 0);
      tick();
    end
    frame_sync = 1'b0;
    run(1);
    chk("t2_one_commit", commit_cnt - c0, 1);
    chk("t2_digits", int'(digits), 'h1234);
    chk("t2_en", int'(digit_en), 'b1111);
    chk("t2_busy", int'(busy), 0);

    // saturation
    send(12000);
    run(15);
    pulse_fs();
    chk("t3_commit", int'(commit), 1);
    chk("t3_digits", int'(digits), 'h9999);

    // latest pending request wins
    send(57);
    run(2);
    send(300);
    run(4);
    send(86);
    run(11);
    pulse_fs();
    chk("t4_first", int'(digits), 'h0057);
    chk("t4_en", int'(digit_en), BLANK ? 'b0011 : 'b1111);
    run(19);
    pulse_fs();
    chk("t4_second", int'(digits), 'h0086);
    chk("t4_commit", int'(commit), 1);
    run(1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_no300", int'(saw300), 0);

    // frame during SHIFT ignored
    c0 = commit_cnt;
    send(4321);
    run(4);
    pulse_fs();
    run(24);
    chk("t5_no_early", commit_cnt - c0, 0);
    pulse_fs();
    chk("t5_commit", int'(commit), 1);
    chk("t5_digits", int'(digits), 'h4321);

    // earliest frame with a simultaneous new request
    send(42);
    run(15);
    score = 14'd905;
    score_valid = 1'b1;
    frame_sync = 1'b1;
    tick();
    score_valid = 1'b0;
    frame_sync = 1'b0;
    chk("t7_commit", int'(commit), 1);
    chk("t7_digits", int'(digits), 'h0042);
    chk("t7_busy", int'(busy), 1);
    run(15);
    pulse_fs();
    chk("t7_second", int'(digits), 'h0905);

    // reset mid-SHIFT with a pending request
    send(777);
    run(2);
    send(555);
    run(2);
    rst_n = 1'b0;
    run(2);
    chk("t6_digits", int'(digits), 0);
    chk("t6_en", int'(digit_en), BLANK ? 1 : 15);
    chk("t6_busy", int'(busy), 0);
    rst_n = 1'b1;
    c0 = commit_cnt;
    repeat (3) begin
      run(10);
      pulse_fs();
    end
    chk("t6_no_commit", commit_cnt - c0, 0);
    chk("t6_busy_after", int'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
